// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, ALU opcodes, forwarding select, ID/EX payload.
package cpu_types_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned SHAMT_W    = 5;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] regbits_t;
    typedef logic [SHAMT_W-1:0]    shamt_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } aluop_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    // Everything the ID/EX register holds for one instruction.
    typedef struct packed {
        logic     valid;
        regbits_t rs;
        regbits_t rt;
        regbits_t rd;
        word_t    rs_data;
        word_t    rt_data;
        word_t    imm;
        shamt_t   shamt;
        aluop_t   alu_op;
        logic     alusrc;
        logic     shift;
        logic     regwrite;
        logic     memread;
        logic     memwrite;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Forwarding mux for one source operand: EX/MEM beats MEM/WB, register 0 never forwards.
module fwd_mux
    import cpu_types_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_reg,
    input  logic [WORD_W-1:0]     held_data,
    input  logic                  exmem_regwrite,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [WORD_W-1:0]     exmem_result,
    input  logic                  memwb_regwrite,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [WORD_W-1:0]     memwb_result,
    output fwd_sel_t              sel_c,
    output logic [WORD_W-1:0]     data_c
);

    // Pick the youngest in-flight producer of src_reg, else the held register-file value.
    always_comb begin
        sel_c  = FWD_NONE;
        data_c = held_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src_reg)) begin
            sel_c  = FWD_EXMEM;
            data_c = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src_reg)) begin
            sel_c  = FWD_MEMWB;
            data_c = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding, load-use bubble insertion and ALU operand select.
module id_ex_operand_stage
    import cpu_types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [WORD_W-1:0]     id_rs_data,
    input  logic [WORD_W-1:0]     id_rt_data,
    input  logic [WORD_W-1:0]     id_imm,
    input  logic [SHAMT_W-1:0]    id_shamt,
    input  aluop_t                id_alu_op,
    input  logic                  id_alusrc,
    input  logic                  id_shift,
    input  logic                  id_uses_rt,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  exmem_regwrite,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [WORD_W-1:0]     exmem_result,
    input  logic                  memwb_regwrite,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [WORD_W-1:0]     memwb_result,
    input  logic                  stall,
    input  logic                  flush,
    output logic [WORD_W-1:0]     port_A,
    output logic [WORD_W-1:0]     port_B,
    output aluop_t                alu_op,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic [WORD_W-1:0]     ex_store_data,
    output logic                  lu_stall
);

    id_ex_t            ex_q;
    id_ex_t            ex_d;
    fwd_sel_t          fwd_rs_sel;
    fwd_sel_t          fwd_rt_sel;
    logic [WORD_W-1:0] fwd_rs_data;
    logic [WORD_W-1:0] fwd_rt_data;

    fwd_mux u_fwd_rs (
        .src_reg        (ex_q.rs),
        .held_data      (ex_q.rs_data),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .sel_c          (fwd_rs_sel),
        .data_c         (fwd_rs_data)
    );

    fwd_mux u_fwd_rt (
        .src_reg        (ex_q.rt),
        .held_data      (ex_q.rt_data),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .sel_c          (fwd_rt_sel),
        .data_c         (fwd_rt_data)
    );

    // Load in EX whose destination is read by the instruction in decode; a redirect cancels it.
    always_comb begin
        lu_stall = 1'b0;
        if (!flush && id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0)) begin
            lu_stall = (ex_q.rd == id_rs) || (id_uses_rt && (ex_q.rd == id_rt));
        end
    end

    // Next held instruction in priority order: flush, stall, load-use bubble, capture.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d.valid    = 1'b0;
            ex_d.regwrite = 1'b0;
            ex_d.memread  = 1'b0;
            ex_d.memwrite = 1'b0;
        end else if (stall) begin
            // Latch forwarded operands so they outlive the producer retiring during the hold.
            if (fwd_rs_sel != FWD_NONE) begin
                ex_d.rs_data = fwd_rs_data;
            end
            if (fwd_rt_sel != FWD_NONE) begin
                ex_d.rt_data = fwd_rt_data;
            end
        end else if (lu_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = id_valid;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.rd       = id_rd;
            ex_d.rs_data  = id_rs_data;
            ex_d.rt_data  = id_rt_data;
            ex_d.imm      = id_imm;
            ex_d.shamt    = id_shamt;
            ex_d.alu_op   = id_alu_op;
            ex_d.alusrc   = id_alusrc;
            ex_d.shift    = id_shift;
            ex_d.regwrite = id_valid & id_regwrite;
            ex_d.memread  = id_valid & id_memread;
            ex_d.memwrite = id_valid & id_memwrite;
        end
    end

    // ID/EX state register with synchronous active-low clear.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // ALU operand select and onward control.
    always_comb begin
        port_A        = ex_q.shift ? WORD_W'(ex_q.shamt) : fwd_rs_data;
        port_B        = ex_q.alusrc ? ex_q.imm : fwd_rt_data;
        ex_store_data = fwd_rt_data;
        alu_op        = ex_q.alu_op;
        ex_valid      = ex_q.valid;
        ex_rd         = ex_q.rd;
        ex_regwrite   = ex_q.valid & ex_q.regwrite;
        ex_memread    = ex_q.valid & ex_q.memread;
        ex_memwrite   = ex_q.valid & ex_q.memwrite;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and randomized bench for id_ex_operand_stage against a behavioural pipeline model.
module tb_id_ex_operand_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    aluop_t      id_alu_op;
    logic        id_alusrc, id_shift, id_uses_rt, id_regwrite, id_memread, id_memwrite;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, flush;
    logic [31:0] port_A, port_B, ex_store_data;
    aluop_t      alu_op;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, lu_stall;
    logic [4:0]  ex_rd;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    id_ex_operand_stage dut (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alu_op(id_alu_op), .id_alusrc(id_alusrc), .id_shift(id_shift), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .flush(flush), .port_A(port_A), .port_B(port_B), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data), .lu_stall(lu_stall)
    );

    // Model of the instruction currently sitting in EX.
    typedef struct {
        bit          valid;
        int          rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        int          shamt;
        int          op;
        bit          alusrc, shift, rw, mr, mw;
    } mdl_t;

    mdl_t m;
    mdl_t n;

    function automatic mdl_t empty_instr();
        mdl_t z;
        z.valid = 0; z.rs = 0; z.rt = 0; z.rd = 0;
        z.rsd = 0; z.rtd = 0; z.imm = 0; z.shamt = 0; z.op = 0;
        z.alusrc = 0; z.shift = 0; z.rw = 0; z.mr = 0; z.mw = 0;
        return z;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Value an EX operand reads: newest writer of that register, register 0 excluded.
    function automatic logic [31:0] m_fwd(input int r, input logic [31:0] held);
        if (exmem_regwrite && exmem_rd != 0 && int'(exmem_rd) == r) return exmem_result;
        if (memwb_regwrite && memwb_rd != 0 && int'(memwb_rd) == r) return memwb_result;
        return held;
    endfunction

    function automatic bit m_lu();
        return !flush && id_valid && m.valid && m.mr && m.rd != 0 &&
               (m.rd == int'(id_rs) || (id_uses_rt && m.rd == int'(id_rt)));
    endfunction

    // Let inputs settle, then compare every output against the model.
    task automatic settle_check();
        logic [31:0] ers, ert;
        #1;
        ers = m_fwd(m.rs, m.rsd);
        ert = m_fwd(m.rt, m.rtd);
        chk("port_A", port_A, m.shift ? 32'(m.shamt) : ers);
        chk("port_B", port_B, m.alusrc ? m.imm : ert);
        chk("store_data", ex_store_data, ert);
        chk("alu_op", 32'(alu_op), 32'(m.op));
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("ex_rd", 32'(ex_rd), 32'(m.rd));
        chk("ex_regwrite", 32'(ex_regwrite), 32'(m.valid && m.rw));
        chk("ex_memread", 32'(ex_memread), 32'(m.valid && m.mr));
        chk("ex_memwrite", 32'(ex_memwrite), 32'(m.valid && m.mw));
        chk("lu_stall", 32'(lu_stall), 32'(m_lu()));
    endtask

    // Advance one clock: predict the held instruction from the current inputs, then commit.
    task automatic clock();
        n = m;
        if (!nRST) begin
            n = empty_instr();
        end else if (flush) begin
            n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
        end else if (stall) begin
            n.rsd = m_fwd(m.rs, m.rsd);
            n.rtd = m_fwd(m.rt, m.rtd);
        end else if (m_lu()) begin
            n = empty_instr();
        end else begin
            n.valid  = id_valid;
            n.rs     = int'(id_rs);
            n.rt     = int'(id_rt);
            n.rd     = int'(id_rd);
            n.rsd    = id_rs_data;
            n.rtd    = id_rt_data;
            n.imm    = id_imm;
            n.shamt  = int'(id_shamt);
            n.op     = int'(id_alu_op);
            n.alusrc = id_alusrc;
            n.shift  = id_shift;
            n.rw     = id_valid && id_regwrite;
            n.mr     = id_valid && id_memread;
            n.mw     = id_valid && id_memwrite;
        end
        @(posedge CLK);
        m = n;
        @(negedge CLK);
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input int rd,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input bit rw, input bit mr, input bit uses_rt);
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_rd       = 5'(rd);
        id_rs_data  = rsd;
        id_rt_data  = rtd;
        id_imm      = 32'hCAFE_0000;
        id_shamt    = 5'd3;
        id_alu_op   = ALU_ADD;
        id_alusrc   = 1'b0;
        id_shift    = 1'b0;
        id_uses_rt  = uses_rt;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = 1'b0;
    endtask

    task automatic no_fwd();
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        m = empty_instr();
        n = empty_instr();
        nRST = 0; stall = 0; flush = 0;
        no_fwd();
        set_id(1, 1, 2, 3, 32'h11, 32'h22, 1, 0, 1);
        @(negedge CLK);

        // Reset held for two edges with a valid instruction presented.
        clock();
        settle_check();
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_port_A", port_A, 32'h0);
        chk("rst_port_B", port_B, 32'h0);
        clock();
        settle_check();
        chk("rst_lu_stall", 32'(lu_stall), 32'h0);

        // EX/MEM wins over MEM/WB; MEM/WB used once EX/MEM stops writing.
        nRST = 1;
        set_id(1, 5, 6, 10, 32'h1111, 32'h2222, 1, 0, 1);
        settle_check();
        clock();
        id_valid = 0;
        exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'h1234;
        memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'hBEEF;
        settle_check();
        chk("fwd_exmem_wins", port_A, 32'h1234);
        exmem_regwrite = 0;
        settle_check();
        chk("fwd_memwb", port_A, 32'hBEEF);
        clock();

        // Register 0 is never forwarded; immediate selected on port B.
        no_fwd();
        set_id(1, 0, 3, 4, 32'hAAAA_0000, 32'h33, 1, 0, 0);
        id_alusrc = 1; id_imm = 32'h10;
        settle_check();
        clock();
        id_valid = 0; id_alusrc = 0;
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
        settle_check();
        chk("r0_not_fwd", port_A, 32'hAAAA_0000);
        chk("imm_port_B", port_B, 32'h10);
        clock();

        // Load-use: one stall cycle, one bubble, then the consumer is captured.
        no_fwd();
        set_id(1, 1, 2, 8, 32'h100, 32'h200, 1, 1, 0);
        id_alusrc = 1;
        settle_check();
        clock();
        set_id(1, 8, 9, 11, 32'h300, 32'h400, 1, 0, 1);
        settle_check();
        chk("lu_detect", 32'(lu_stall), 32'h1);
        clock();
        settle_check();
        chk("lu_bubble", 32'(ex_valid), 32'h0);
        chk("lu_one_cycle", 32'(lu_stall), 32'h0);
        clock();
        settle_check();
        chk("lu_capture_valid", 32'(ex_valid), 32'h1);
        chk("lu_capture_rd", 32'(ex_rd), 32'd11);
        set_id(1, 1, 2, 8, 32'h100, 32'h200, 1, 1, 0);
        settle_check();
        clock();
        set_id(1, 0, 9, 12, 32'h500, 32'h600, 1, 0, 0);
        settle_check();
        chk("lu_rs0_none", 32'(lu_stall), 32'h0);
        clock();

        // Forwarded operand survives a 3-cycle stall after the producer leaves.
        set_id(1, 7, 12, 13, 32'h1, 32'h2, 1, 0, 1);
        settle_check();
        clock();
        id_valid = 0; stall = 1;
        memwb_regwrite = 1; memwb_rd = 7; memwb_result = 32'h55;
        settle_check();
        chk("stall_fwd_0", port_A, 32'h55);
        clock();
        memwb_regwrite = 0;
        for (int i = 1; i < 3; i++) begin
            settle_check();
            chk("stall_hold", port_A, 32'h55);
            clock();
        end
        stall = 0;
        settle_check();
        chk("stall_release", port_A, 32'h55);
        clock();

        // Flush beats stall; then reset mid-stall clears everything.
        set_id(1, 1, 2, 3, 32'h7, 32'h8, 1, 0, 1);
        settle_check();
        clock();
        flush = 1; stall = 1;
        settle_check();
        clock();
        settle_check();
        chk("flush_valid", 32'(ex_valid), 32'h0);
        chk("flush_regwrite", 32'(ex_regwrite), 32'h0);
        flush = 0; stall = 0;
        set_id(1, 4, 5, 6, 32'h9, 32'hA, 1, 0, 1);
        id_shift = 1;
        settle_check();
        clock();
        stall = 1; nRST = 0;
        settle_check();
        clock();
        nRST = 1; stall = 0; id_valid = 0;
        settle_check();
        chk("rst_mid_valid", 32'(ex_valid), 32'h0);
        chk("rst_mid_port_A", port_A, 32'h0);
        chk("rst_mid_port_B", port_B, 32'h0);
        clock();

        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            nRST           = ($urandom_range(0, 49) != 0);
            flush          = ($urandom_range(0, 11) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            id_valid       = ($urandom_range(0, 3) != 0);
            id_rs          = 5'($urandom_range(0, 7));
            id_rt          = 5'($urandom_range(0, 7));
            id_rd          = 5'($urandom_range(0, 7));
            id_rs_data     = $urandom;
            id_rt_data     = $urandom;
            id_imm         = $urandom;
            id_shamt       = 5'($urandom);
            id_alu_op      = aluop_t'(4'($urandom_range(0, 10)));
            id_alusrc      = 1'($urandom);
            id_shift       = ($urandom_range(0, 3) == 0);
            id_uses_rt     = 1'($urandom);
            id_regwrite    = 1'($urandom);
            id_memread     = ($urandom_range(0, 2) == 0);
            id_memwrite    = 1'($urandom);
            exmem_regwrite = 1'($urandom);
            exmem_rd       = 5'($urandom_range(0, 7));
            exmem_result   = $urandom;
            memwb_regwrite = 1'($urandom);
            memwb_rd       = 5'($urandom_range(0, 7));
            memwb_result   = $urandom;
            settle_check();
            clock();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
